// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and the round/saturate helper for the FIR MAC sequencer.
package fir_pkg;

  localparam int DEF_NTAP  = 16;
  localparam int DEF_DW    = 16;
  localparam int DEF_CW    = 16;
  localparam int DEF_ACCW  = 40;
  localparam int DEF_SHIFT = 15;

  typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

  // clip sits in the LSB so a caller can take {value[dw-1:0], clip} with one cast
  typedef struct packed {
    logic [63:0] val;
    logic        clip;
  } rnd_t;

  // Round half-up, arithmetic shift, then clamp to a dw-bit signed range. shift >= 1.
  function automatic rnd_t sat_round(input logic signed [63:0] acc, input int shift, input int dw);
    logic signed [63:0] r, hi, lo;
    rnd_t o;
    r      = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi     = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (dw - 1));
    o.clip = (r > hi) || (r < lo);
    o.val  = (r > hi) ? hi : ((r < lo) ? lo : r);
    return o;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// NTAP-deep circular sample store; reads tap k back from the most recently written slot.
module fir_sample_ring #(
  parameter int NTAP = 16,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DW-1:0]           wdata,
  input  logic                    adv,
  input  logic [$clog2(NTAP)-1:0] k,
  output logic [DW-1:0]           rdata
);

  localparam int AW = $clog2(NTAP);

  logic [NTAP-1:0][DW-1:0] mem;
  logic [AW-1:0]           wp;
  logic [AW-1:0]           ridx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
      wp  <= '0;
    end else begin
      if (we)  mem[wp] <= wdata;
      if (adv) wp      <= wp + 1'b1;
    end
  end

  // NTAP is a power of two, so AW-bit wraparound is the modulo
  assign ridx  = wp - k;
  assign rdata = mem[ridx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample in, NTAP serial MACs, round/saturate, one sample out.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAP  = DEF_NTAP,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int ACCW  = DEF_ACCW,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [DW-1:0]    s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [DW-1:0]    m_data,
  input  logic                    coef_we,
  input  logic [$clog2(NTAP)-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_wdata,
  output logic                    busy,
  output logic                    sat,
  output logic                    coef_err
);

  localparam int AW = $clog2(NTAP);
  localparam int PW = DW + CW;

  state_t                  state;
  logic [AW-1:0]           k;
  logic signed [ACCW-1:0]  acc;
  logic [NTAP-1:0][CW-1:0] coef;

  logic signed [DW-1:0]    tap;
  logic signed [CW-1:0]    hk;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_nxt;
  logic                    accept;
  logic                    last;

  assign accept = s_valid && s_ready;
  assign last   = (k == AW'(NTAP - 1));

  fir_sample_ring #(.NTAP(NTAP), .DW(DW)) u_ring (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .wdata (s_data),
    .adv   (state == MAC && last),
    .k     (k),
    .rdata (tap)
  );

  assign hk      = coef[k];
  assign prod    = tap * hk;
  assign acc_nxt = acc + ACCW'(prod);

  // Bank only changes while idle, so a MAC pass always sees one consistent set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         coef            <= '0;
    else if (coef_we && state == IDLE) coef[coef_addr] <= coef_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
      sat      <= 1'b0;
      coef_err <= 1'b0;
      k        <= '0;
      acc      <= '0;
    end else begin
      sat      <= 1'b0;
      coef_err <= coef_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= '0;
            k       <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (last) begin
            k     <= '0;
            state <= RND;
          end else begin
            k <= k + 1'b1;
          end
        end
        RND: begin
          {m_data, sat} <= (DW + 1)'(sat_round(64'(acc), SHIFT, DW));
          m_valid       <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: vector table plus backpressure, coefficient and reset sequences.
module tb_fir_mac_sequencer;

  localparam int NTAP = 16;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int NV   = 25;
  localparam int TMO  = 200;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic signed [DW-1:0] m_data;
  logic                 coef_we = 1'b0;
  logic [3:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 busy;
  logic                 sat;
  logic                 coef_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_last = 0;
  int hs_prev = 0;

  typedef struct {
    bit rst;
    int prof;
    int din;
    int dout;
    bit dsat;
    bit gap;
  } vec_t;

  vec_t tbl [NV];

  fir_mac_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy),
    .sat        (sat),
    .coef_err   (coef_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid && s_ready) begin
      hs_prev <= hs_last;
      hs_last <= cyc;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input bit rst, input int prof, input int din,
                      input int dout, input bit dsat, input bit gap);
    tbl[i].rst  = rst;
    tbl[i].prof = prof;
    tbl[i].din  = din;
    tbl[i].dout = dout;
    tbl[i].dsat = dsat;
    tbl[i].gap  = gap;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = a[3:0];
    coef_wdata = d[15:0];
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  task automatic load_prof(input int p);
    case (p)
      0: for (int j = 0; j < 4; j++) wcoef(j, 8192);
      1: for (int j = 0; j < NTAP; j++) wcoef(j, 32 * (j + 1));
      default: begin
        wcoef(0, 32767);
        wcoef(1, 32767);
      end
    endcase
  endtask

  // Returns on the falling edge just after the input handshake edge
  task automatic start_sample(input int din);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    s_valid = 1'b1;
    s_data  = din[15:0];
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic finish_sample(output int dout, output bit dsat, output int lat);
    lat = 0;
    while (!m_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    if (!m_valid) chk("m_valid_timeout", 0, 1);
    dout = $signed(m_data);
    dsat = sat;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d;
    bit s;
    int l;

    setv(0, 1'b1, 0, 4000, 1000, 1'b0, 1'b0);
    setv(1, 1'b0, 0, 4000, 2000, 1'b0, 1'b1);
    setv(2, 1'b0, 0, 4000, 3000, 1'b0, 1'b1);
    setv(3, 1'b0, 0, 4000, 4000, 1'b0, 1'b1);
    setv(4, 1'b0, 0, 4000, 4000, 1'b0, 1'b1);
    setv(5, 1'b1, 1, 1024, 1, 1'b0, 1'b0);
    for (int j = 1; j < NTAP; j++) setv(5 + j, 1'b0, 1, 0, j + 1, 1'b0, 1'b1);
    setv(21, 1'b1, 2, 32767, 32766, 1'b0, 1'b0);
    setv(22, 1'b0, 2, 32767, 32767, 1'b1, 1'b1);
    setv(23, 1'b1, 2, -32768, -32767, 1'b0, 1'b0);
    setv(24, 1'b0, 2, -32768, -32768, 1'b1, 1'b1);

    #12;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", $signed(m_data), 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_coef_err", coef_err, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        load_prof(tbl[i].prof);
      end
      start_sample(tbl[i].din);
      if (tbl[i].gap) chk($sformatf("gap[%0d]", i), hs_last - hs_prev, NTAP + 3);
      finish_sample(d, s, l);
      chk($sformatf("lat[%0d]", i), l, NTAP + 1);
      chk($sformatf("out[%0d]", i), d, tbl[i].dout);
      chk($sformatf("sat[%0d]", i), s, tbl[i].dsat);
    end

    // Output held under backpressure; stray s_valid pulses must not enter the ring
    do_reset();
    wcoef(0, 8192);
    wcoef(1, 8192);
    m_ready = 1'b0;
    start_sample(4000);
    finish_sample(d, s, l);
    chk("bp_first", d, 1000);
    for (int i = 0; i < 6; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = 16'sd20000;
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", i), m_valid, 1);
      chk($sformatf("bp_hold[%0d]", i), $signed(m_data), 1000);
      chk($sformatf("bp_sready[%0d]", i), s_ready, 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", m_valid, 0);
    chk("bp_release_sready", s_ready, 1);
    start_sample(4000);
    finish_sample(d, s, l);
    chk("bp_next", d, 2000);

    // Coefficient write while busy is dropped and flagged
    do_reset();
    wcoef(0, 8192);
    start_sample(4000);
    coef_we    = 1'b1;
    coef_addr  = 4'd0;
    coef_wdata = 16'sd16384;
    @(negedge clk);
    coef_we = 1'b0;
    chk("cerr_pulse", coef_err, 1);
    @(negedge clk);
    chk("cerr_clear", coef_err, 0);
    finish_sample(d, s, l);
    chk("busy_write_out", d, 1000);
    start_sample(4000);
    finish_sample(d, s, l);
    chk("coef_unchanged", d, 1000);

    // Write at the same edge as the sample handshake is used by that sample
    @(negedge clk);
    chk("idle_sready", s_ready, 1);
    s_valid    = 1'b1;
    s_data     = 16'sd4000;
    coef_we    = 1'b1;
    coef_addr  = 4'd1;
    coef_wdata = 16'sd8192;
    @(negedge clk);
    s_valid = 1'b0;
    coef_we = 1'b0;
    chk("cerr_idle", coef_err, 0);
    finish_sample(d, s, l);
    chk("same_edge_coef", d, 2000);

    // Asynchronous reset in the middle of a MAC pass
    start_sample(4000);
    @(negedge clk);
    @(negedge clk);
    chk("busy_mac", busy, 1);
    chk("sready_mac", s_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 1);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", $signed(m_data), 0);
    chk("arst_busy", busy, 0);
    chk("arst_sat", sat, 0);
    chk("arst_coef_err", coef_err, 0);
    @(negedge clk);
    reset = 1'b0;
    start_sample(1000);
    finish_sample(d, s, l);
    chk("post_rst_lat", l, NTAP + 1);
    chk("post_rst_out", d, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
